// File: rtl/dataram_pkg.sv
// rtl/dataram_pkg.sv - shared data RAM geometry and response owner encoding
package dataram_pkg;

  localparam int RAM_AW     = 30;
  localparam int RAM_DW     = 32;
  localparam int RAM_BE_W   = 4;
  localparam int RAM_IDX_W  = 12;
  localparam int RAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

endpackage

// File: rtl/dataram_arbiter_arb2_pick.sv
// rtl/dataram_arbiter_arb2_pick.sv - combinational two-way winner select
module arb2_pick (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       prio1_i,
  output logic [1:0] gnt_o
);

  // One-hot winner; prio1_i only matters under contention
  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i) begin
      gnt_o = prio1_i ? 2'b10 : 2'b01;
    end else if (req0_i) begin
      gnt_o = 2'b01;
    end else if (req1_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/dataram_arbiter.sv
// rtl/dataram_arbiter.sv - two-master data RAM arbiter; DATARAM_ARB_RR_EN selects round-robin
module dataram_arbiter
  import dataram_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 15,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req_i,
  input  logic [RAM_BE_W-1:0] m0_we_i,
  input  logic [RAM_AW-1:0]   m0_addr_i,
  input  logic [RAM_DW-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [RAM_DW-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic [RAM_BE_W-1:0] m1_we_i,
  input  logic [RAM_AW-1:0]   m1_addr_i,
  input  logic [RAM_DW-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [RAM_DW-1:0]   m1_rdata_o,
  output logic [RAM_BE_W-1:0] ram_wea_o,
  output logic [RAM_AW-1:0]   ram_addra_o,
  output logic [RAM_DW-1:0]   ram_dina_o,
  input  logic [RAM_DW-1:0]   ram_douta_i
);

  logic [1:0] pick;
  logic       prio1;
  owner_e     rsp_owner_q, rsp_owner_d;

  arb2_pick u_pick (
    .req0_i  (m0_req_i),
    .req1_i  (m1_req_i),
    .prio1_i (prio1),
    .gnt_o   (pick)
  );

  // Grants are suppressed during reset so no write can reach the RAM
  assign m0_gnt_o = pick[0] & rst_n;
  assign m1_gnt_o = pick[1] & rst_n;

`ifdef DATARAM_ARB_RR_EN
  // rr_last_q = 1 means m1 held the most recent grant
  logic rr_last_q, rr_last_d;

  assign prio1 = ~rr_last_q;

  // Remember the last granted master; hold when idle
  always_comb begin
    rr_last_d = rr_last_q;
    if (m1_gnt_o) begin
      rr_last_d = 1'b1;
    end else if (m0_gnt_o) begin
      rr_last_d = 1'b0;
    end
  end

  // Round-robin history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  logic [CNT_W-1:0] starve_q, starve_d;

  assign prio1 = (starve_q >= CNT_W'(STARVE_MAX));

  // Count refused m1 cycles, saturating; any m1 grant or idle m1 clears it
  always_comb begin
    starve_d = '0;
    if (m1_req_i && !m1_gnt_o) begin
      starve_d = (starve_q >= CNT_W'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Steer the granted payload to the RAM; m0 payload is the idle default
  always_comb begin
    ram_wea_o   = '0;
    ram_addra_o = m0_addr_i;
    ram_dina_o  = m0_wdata_i;
    if (m1_gnt_o) begin
      ram_wea_o   = m1_we_i;
      ram_addra_o = m1_addr_i;
      ram_dina_o  = m1_wdata_i;
    end else if (m0_gnt_o) begin
      ram_wea_o = m0_we_i;
    end
  end

  // Owner of the response that the RAM returns next cycle
  always_comb begin
    rsp_owner_d = OWN_NONE;
    if (m0_gnt_o) begin
      rsp_owner_d = OWN_M0;
    end else if (m1_gnt_o) begin
      rsp_owner_d = OWN_M1;
    end
  end

  // Response pipeline register; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_owner_q <= OWN_NONE;
    end else begin
      rsp_owner_q <= rsp_owner_d;
    end
  end

  assign m0_rvalid_o = (rsp_owner_q == OWN_M0);
  assign m1_rvalid_o = (rsp_owner_q == OWN_M1);
  assign m0_rdata_o  = ram_douta_i;
  assign m1_rdata_o  = ram_douta_i;

endmodule

// File: tb/tb_dataram_arbiter.sv
// tb/tb_dataram_arbiter.sv - directed vector bench for dataram_arbiter
module tb_dataram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [3:0]  m0_we, m1_we;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  ram_wea;
  logic [29:0] ram_addra;
  logic [31:0] ram_dina, ram_douta;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dataram_arbiter #(.STARVE_MAX(3), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .ram_wea_o   (ram_wea),
    .ram_addra_o (ram_addra),
    .ram_dina_o  (ram_dina),
    .ram_douta_i (ram_douta)
  );

  // Behavioural RAM: 4K words, byte enables, old data on read-during-write,
  // out-of-range addresses ignore writes and read as zero
  logic [31:0] mem [4096];
  always @(posedge clk) begin
    if (ram_addra[29:12] != 18'd0) begin
      ram_douta <= 32'd0;
    end else begin
      ram_douta <= mem[ram_addra[11:0]];
      for (int b = 0; b < 4; b++) begin
        if (ram_wea[b]) mem[ram_addra[11:0]][b*8 +: 8] <= ram_dina[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        m0_req;
    logic [3:0]  m0_we;
    logic [29:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic [3:0]  m1_we;
    logic [29:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic [3:0] w0, input logic [29:0] a0,
                              input logic [31:0] d0, input logic r1, input logic [3:0] w1,
                              input logic [29:0] a1, input logic [31:0] d1,
                              input logic [1:0] eg, input logic [1:0] erv,
                              input logic cr, input logic [31:0] erd);
    vec_t v;
    v.m0_req = r0; v.m0_we = w0; v.m0_addr = a0; v.m0_wdata = d0;
    v.m1_req = r1; v.m1_we = w1; v.m1_addr = a1; v.m1_wdata = d1;
    v.exp_gnt = eg; v.exp_rv = erv; v.chk_rd = cr; v.exp_rd = erd;
    return v;
  endfunction

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  vec_t vt [14];
  logic [1:0] prev_gnt;
  logic [1:0] eg;
  logic [3:0] exp_wea;

  initial begin
    vt[0]  = mk(0, 4'h0, 30'h0,     32'h0,        0, 4'h0, 30'h0,  32'h0,        2'b00, 2'b00, 0, 32'h0);
    vt[1]  = mk(1, 4'hF, 30'h10,    32'hDEADBEEF, 0, 4'h0, 30'h0,  32'h0,        2'b01, 2'b00, 0, 32'h0);
    vt[2]  = mk(1, 4'h0, 30'h10,    32'h0,        0, 4'h0, 30'h0,  32'h0,        2'b01, 2'b01, 0, 32'h0);
    vt[3]  = mk(0, 4'h0, 30'h0,     32'h0,        1, 4'h2, 30'h10, 32'h0000AA00, 2'b10, 2'b01, 1, 32'hDEADBEEF);
    vt[4]  = mk(0, 4'h0, 30'h0,     32'h0,        1, 4'h0, 30'h10, 32'h0,        2'b10, 2'b10, 1, 32'hDEADBEEF);
    vt[5]  = mk(0, 4'h0, 30'h0,     32'h0,        0, 4'h0, 30'h0,  32'h0,        2'b00, 2'b10, 1, 32'hDEADAAEF);
    vt[6]  = mk(1, 4'hF, 30'h0,     32'h11111111, 0, 4'h0, 30'h0,  32'h0,        2'b01, 2'b00, 0, 32'h0);
    vt[7]  = mk(1, 4'hF, 30'h10000, 32'h12345678, 0, 4'h0, 30'h0,  32'h0,        2'b01, 2'b01, 0, 32'h0);
    vt[8]  = mk(1, 4'h0, 30'h10000, 32'h0,        0, 4'h0, 30'h0,  32'h0,        2'b01, 2'b01, 1, 32'h0);
    vt[9]  = mk(1, 4'h0, 30'h0,     32'h0,        0, 4'h0, 30'h0,  32'h0,        2'b01, 2'b01, 1, 32'h0);
    vt[10] = mk(0, 4'h0, 30'h0,     32'h0,        1, 4'h0, 30'h10, 32'h0,        2'b10, 2'b01, 1, 32'h11111111);
    vt[11] = mk(1, 4'h0, 30'h10,    32'h0,        1, 4'h0, 30'h0,  32'h0,        2'b01, 2'b10, 1, 32'hDEADAAEF);
    vt[12] = mk(0, 4'h0, 30'h0,     32'h0,        1, 4'h0, 30'h0,  32'h0,        2'b10, 2'b01, 1, 32'hDEADAAEF);
    vt[13] = mk(0, 4'h0, 30'h0,     32'h0,        0, 4'h0, 30'h0,  32'h0,        2'b00, 2'b10, 1, 32'h11111111);

    // Reset state: requests present but grants and write enables held off
    rst_n = 1'b0;
    idle();
    m0_req = 1; m0_we = 4'hF; m1_req = 1;
    #12;
    chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_wea", {28'd0, ram_wea}, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Table-driven functional vectors, one row per cycle
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      m0_req = vt[i].m0_req; m0_we = vt[i].m0_we; m0_addr = vt[i].m0_addr; m0_wdata = vt[i].m0_wdata;
      m1_req = vt[i].m1_req; m1_we = vt[i].m1_we; m1_addr = vt[i].m1_addr; m1_wdata = vt[i].m1_wdata;
      #1;
      chk($sformatf("vec%0d_gnt", i), {30'd0, m1_gnt, m0_gnt}, {30'd0, vt[i].exp_gnt});
      chk($sformatf("vec%0d_rvalid", i), {30'd0, m1_rvalid, m0_rvalid}, {30'd0, vt[i].exp_rv});
      exp_wea = vt[i].exp_gnt[1] ? vt[i].m1_we : (vt[i].exp_gnt[0] ? vt[i].m0_we : 4'h0);
      chk($sformatf("vec%0d_wea", i), {28'd0, ram_wea}, {28'd0, exp_wea});
      if (vt[i].exp_gnt != 2'b00)
        chk($sformatf("vec%0d_addr", i), {2'd0, ram_addra},
            {2'd0, vt[i].exp_gnt[1] ? vt[i].m1_addr : vt[i].m0_addr});
      if (vt[i].chk_rd)
        chk($sformatf("vec%0d_rdata", i), vt[i].exp_rv[1] ? m1_rdata : m0_rdata, vt[i].exp_rd);
    end

    // Continuous contention: starvation override (or round-robin) pattern
    prev_gnt = 2'b00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = 30'h10;
      m1_req = 1; m1_we = 0; m1_addr = 30'h0;
      #1;
`ifdef DATARAM_ARB_RR_EN
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      eg = (i % 4 == 3) ? 2'b10 : 2'b01;
`endif
      chk($sformatf("cont%0d_gnt", i), {30'd0, m1_gnt, m0_gnt}, {30'd0, eg});
      chk($sformatf("cont%0d_rvalid", i), {30'd0, m1_rvalid, m0_rvalid}, {30'd0, prev_gnt});
      prev_gnt = eg;
    end
    @(negedge clk);
    idle();
    #1;
    chk("cont_tail_rvalid", {30'd0, m1_rvalid, m0_rvalid}, {30'd0, prev_gnt});
    @(negedge clk);

    // Reset mid-access: granted read is dropped, write during reset is blocked
    m0_req = 1; m0_we = 0; m0_addr = 30'h10;
    #1;
    chk("mid_gnt_pre", {31'd0, m0_gnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    m0_we = 4'hF; m0_wdata = 32'h0BAD0BAD;
    #1;
    chk("mid_gnt_rst", {31'd0, m0_gnt}, 32'd0);
    chk("mid_wea_rst", {28'd0, ram_wea}, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    chk("mid_rvalid0", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    @(negedge clk);
    #1;
    chk("mid_rvalid1", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    m0_req = 1; m0_we = 0; m0_addr = 30'h10;
    #1;
    chk("post_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    @(negedge clk);
    idle();
    #1;
    chk("post_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
    chk("post_rdata", m0_rdata, 32'hDEADAAEF);
    @(negedge clk);
    #1;
    chk("post_idle_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dataram_arbiter.md
Name: dataram_arbiter

Overview:
- Two-master arbiter and sequencer for the single synchronous port of the data RAM (4 KiB words, byte write enables, 1-cycle read latency).
- Master 0 is the CPU load/store unit; master 1 is the debug module.
- Grants at most one access per cycle, drives the RAM port combinationally in the grant cycle, and routes the registered read data back to the granted master one cycle later.
- Guarantees forward progress for the debug master with a starvation counter.

Parameters:
- STARVE_MAX, 15: consecutive cycles m1 may be refused while requesting before it is forced to win the next arbitration; legal range 1..255.
- CNT_W, 8: width of the starvation counter; must hold STARVE_MAX.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  CPU access request; held with its payload until m0_gnt.
- m0_we  in  4  CPU byte write enables; 0 = read.
- m0_addr  in  30  CPU word address [31:2].
- m0_wdata  in  32  CPU write data.
- m0_gnt  out  1  CPU request accepted this cycle.
- m0_rvalid  out  1  CPU response valid (one cycle after m0_gnt).
- m0_rdata  out  32  CPU read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for the debug master.
- ram_wea  out  4  to RAM write enables.
- ram_addra  out  30  to RAM address.
- ram_dina  out  32  to RAM write data.
- ram_douta  in  32  from RAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset, asynchronous on rst_n low:
  - rsp_owner cleared to none; starvation counter = 0; rr_last = m1.
  - m0_rvalid = m1_rvalid = 0.
  - gnt outputs are combinational and are forced to 0 while rst_n = 0, so ram_wea = 0.
- Arbitration is combinational each cycle.
  - With no request: no grant, ram_wea = 0, ram_addra/ram_dina = m0 payload (don't-care).
  - With a single request: that master is granted.
  - With both requesting: m0 wins, unless the starvation counter has reached STARVE_MAX; then m1 wins.
- Grant cycle:
  - ram_wea/ram_addra/ram_dina = the granted master's we/addr/wdata.
  - The RAM samples them on the same edge.
- Response pipeline:
  - A 1-bit valid and 1-bit owner register capture the grant.
  - In the next cycle, rvalid of the owner = 1 and the other rvalid = 0.
  - Both rdata outputs = ram_douta; non-owner rdata is don't-care.
- Write responses:
  - Writes also return rvalid, as an acknowledgement.
  - rdata for a write is the pre-write word, because RAM read-during-write returns the old contents.
- Throughput: fully pipelined. A new grant may issue in the same cycle as the previous response, so back-to-back accesses run at 1 per cycle.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle m1_req = 1 and m1_gnt = 0.
  - Clears to 0 on m1_gnt or when m1_req = 0.
- Out-of-range addresses (addr[31:14] ≠ 0): passed through unchanged. The RAM ignores the write and returns 0; rvalid is still produced.
- Requesters must not change payload while req = 1 and gnt = 0. The arbiter does not latch requests.
- Reset mid-access: a pending response is dropped and no rvalid is issued after reset release. A write presented in the reset cycle is not performed, because ram_wea is forced to 0.

Optional Feature:
- Macro: DATARAM_ARB_RR_EN.
- Defined: contention is resolved round-robin. The master not granted last (rr_last) wins; rr_last updates on every grant. The starvation counter and STARVE_MAX are not built and are ignored.
- Undefined: fixed m0 priority with the starvation override described above.

Decomposition:
- Shared package dataram_pkg:
  - RAM_AW = 30, RAM_DW = 32, RAM_BE_W = 4, RAM_IDX_W = 12.
  - Owner enum: OWN_NONE, OWN_M0, OWN_M1.
  - Constant RAM_RD_LAT = 1.
- Sub-module arb2_pick: combinational two-way winner select. Inputs: two reqs, a priority hint (starvation flag or rr_last). Output: one-hot grant.
- Response register and counter stay in the top module.

Test Plan:
- Write then read: m0 writes we=4'hF, addr=0x10, wdata=0xDEADBEEF. Then m0 reads addr 0x10 → m0_rvalid one cycle after each gnt; read returns 0xDEADBEEF; m1_rvalid stays 0.
- Byte write: after the above, m1 writes we=4'b0010, wdata=0x0000AA00 to addr 0x10, then reads it → 0xDEADAAEF on m1_rdata.
- Starvation (fixed priority, STARVE_MAX=3): m0_req and m1_req held high continuously → m0 granted 3 consecutive cycles, m1 granted on the 4th, pattern repeats; no cycle grants both.
- Round-robin (DATARAM_ARB_RR_EN): both requesting continuously from reset → grants alternate m0, m1, m0, m1...
- Out-of-range: m0 writes 0x12345678 to addr 30'h0001_0000, then reads it → rvalid asserted, rdata = 0; RAM word 0 unchanged.
- Reset mid-access: m0 read granted, rst_n pulled low before the next edge → no m0_rvalid after release; the following m0 read completes normally with correct data.
